// File: rtl/hba_master_ctrl.sv
// HBA bus master: accepts one command at a time, arbitrates for the bus, runs a
// single select/xferack transfer and returns read data or a timeout flag.
module hba_master_ctrl #(
    parameter int unsigned DBUS_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DBUS_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DBUS_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  master_request,
    input  logic                  hba_mgrant,
    output logic                  master_select,
    output logic                  master_rnw,
    output logic [ADDR_WIDTH-1:0] master_abus,
    output logic [DBUS_WIDTH-1:0] master_dbus,
    input  logic                  hba_xferack,
    input  logic [DBUS_WIDTH-1:0] hba_dbus_slave
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] XFER = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rnw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DBUS_WIDTH-1:0] wdata_q;
    logic [DBUS_WIDTH-1:0] rdata_d;
    logic                  timeout_d;
    logic                  accept;

    assign accept = (state_q == IDLE) && cmd_ready && cmd_valid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rsp_rdata;
        timeout_d = rsp_timeout;
        case (state_q)
            IDLE: begin
                if (accept) state_d = REQ;
            end
            REQ: begin
                if (hba_mgrant) state_d = XFER;
            end
            XFER: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack on the final counted cycle still completes normally.
                if (hba_xferack) begin
                    rdata_d   = rnw_q ? hba_dbus_slave : '0;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    rdata_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            rnw_q   <= cmd_rnw;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
        end
    end

    // Outputs are registered from the next state so every bus signal is a flop.
    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_timeout    <= 1'b0;
            master_request <= 1'b0;
            master_select  <= 1'b0;
            master_rnw     <= 1'b0;
            master_abus    <= '0;
            master_dbus    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd_ready      <= (state_d == IDLE);
            rsp_valid      <= (state_d == RESP);
            rsp_rdata      <= rdata_d;
            rsp_timeout    <= timeout_d;
            master_request <= (state_d == REQ) || (state_d == XFER);
            master_select  <= (state_d == XFER);
            master_rnw     <= (state_d == XFER) && rnw_q;
            master_abus    <= (state_d == XFER) ? addr_q : '0;
            master_dbus    <= ((state_d == XFER) && !rnw_q) ? wdata_q : '0;
        end
    end

endmodule
